bin_maxpool_2x2: RTL and testbench
==================================

Name: bin_maxpool_2x2

Overview:
- Downstream consumer of the 64-channel XNOR/threshold array output stream.
- Accepts one 64-bit binary pixel per valid beat in raster order: row-major, all channels of one pixel per beat.
- Performs 2x2 stride-2 max-pooling per channel. For binary activations this is a bitwise OR over the window.
- Emits pooled pixels to the next layer's input buffer. A half-width line buffer holds partial results between row pairs.

Parameters:
- CH, 64, channels per pixel (bit width of in_data/out_data).
- MAX_W, 64, maximum feature-map width in pixels.
- DIM_BITS, 7, width of cfg_width/cfg_height and internal row/column counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; latches cfg_width/cfg_height and begins a frame; honoured only in IDLE.
- cfg_width  in  DIM_BITS  input frame width, 1..MAX_W.
- cfg_height  in  DIM_BITS  input frame height, >=1.
- in_valid  in  1  input beat qualifier; no backpressure exists upstream.
- in_data  in  CH  binary pixel, bit c = channel c.
- out_valid  out  1  pooled pixel qualifier.
- out_data  out  CH  pooled pixel.
- busy  out  1  high in RUN or DRAIN.
- frame_done  out  1  one-cycle pulse after the last output of a frame.
- err  out  1  sticky; set by illegal config or by in_valid outside RUN; cleared only by rst or by an accepted start.

Behaviour:
- Reset values: state=IDLE; out_valid=0, out_data=0, busy=0, frame_done=0, err=0; counters=0. Line buffer contents are don't-care.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on start with legal config (1<=cfg_width<=MAX_W, cfg_height>=1). Clears col, row and err.
- Illegal config on start: remain IDLE, set err.
- RUN, per in_valid beat:
  - Even column: hold in_data in h_reg.
  - Odd column: pair = h_reg | in_data.
  - Even row: lb[col>>1] <= pair.
  - Odd row: next cycle out_valid=1, out_data = lb[col>>1] | pair.
- Latency: 1 cycle from the accepting beat to out_valid. out_valid is a single-cycle pulse per output.
- Counters: col increments per beat and wraps to 0 at cfg_width-1; row increments on wrap.
- Frame end: after the beat at (cfg_height-1, cfg_width-1), go to IDLE and pulse frame_done one cycle after the final out_valid, or one cycle after the last beat if no output is pending.
- Floor behaviour (default):
  - Odd width: last column accepted and discarded.
  - Odd height: last row accepted, no lb write, no output.
  - Output size = floor(W/2) x floor(H/2).
  - W=1 or H=1 produces no outputs; frame_done still pulses.
- in_valid in IDLE or DRAIN: beat ignored, err set.
- start while busy: ignored, no error.
- Simultaneous last beat and start in the same cycle: start ignored.
- rst mid-frame: immediate return to IDLE; any pending output is suppressed.
- Width rules: the line buffer holds MAX_W/2 entries x CH bits. Read is combinational at index col>>1. A write and a read never target the same index in the same cycle.

Optional Feature:
- Macro: BINPOOL_CEIL_EN.
- Defined: ceil mode, with zero padding (OR identity).
  - Odd width: last column is treated as a pair with a zero partner, so pair = in_data.
  - Odd height: last row writes lb. On its final beat, go to DRAIN and emit lb[0..ceil(W/2)-1], one per cycle with out_valid held high. Then pulse frame_done and return to IDLE.
  - Output size = ceil(W/2) x ceil(H/2).
- Undefined: floor behaviour as above; the DRAIN state is unreachable and optimised away.

Test Plan:
- W=4, H=2. Row0 = 0x1,0x2,0x4,0x8; row1 = 0x10,0x20,0x40,0x80 -> exactly two outputs, 0x33 then 0xCC. Each appears 1 cycle after row1 beats 1 and 3. frame_done follows the 0xCC output by 1 cycle.
- W=64, H=64, random data with gaps in in_valid -> 1024 outputs matching a reference OR-pool model; bit 63 is exercised; err=0.
- W=3, H=3, all pixels 0xFFFF_FFFF_FFFF_FFFF:
  - floor mode -> 1 output, all-ones.
  - BINPOOL_CEIL_EN -> 4 outputs, all-ones; the last 2 come from back-to-back DRAIN cycles.
- start with cfg_width=0, then with cfg_width=65 -> stay IDLE, err=1. A legal start then clears err.
- in_valid pulsed in IDLE -> err=1, no out_valid. rst asserted mid-frame after 5 beats -> busy=0 and out_valid=0 immediately. The next frame pools correctly.
- W=1, H=5 in floor mode -> no out_valid; frame_done pulses once after the 5th beat.

Source files
------------

// File: rtl/bin_maxpool_2x2.sv
// 2x2 stride-2 max-pool over a binary 64-channel raster stream: a bitwise OR per window.
// Define BINPOOL_CEIL_EN for ceil-mode (zero-padded) pooling with a DRAIN pass; the default is floor mode.
module bin_maxpool_2x2 #(
    parameter int CH       = 64,
    parameter int MAX_W    = 64,
    parameter int DIM_BITS = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DIM_BITS-1:0] cfg_width,
    input  logic [DIM_BITS-1:0] cfg_height,
    input  logic                in_valid,
    input  logic [CH-1:0]       in_data,
    output logic                out_valid,
    output logic [CH-1:0]       out_data,
    output logic                busy,
    output logic                frame_done,
    output logic                err
);

    localparam int LB_N  = MAX_W / 2;
    localparam int LB_AW = (LB_N > 1) ? $clog2(LB_N) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [DIM_BITS-1:0] ONE   = DIM_BITS'(1);
    localparam logic [DIM_BITS-1:0] MAXWD = DIM_BITS'(MAX_W);

`ifdef BINPOOL_CEIL_EN
    localparam logic CEIL_EN = 1'b1;
`else
    localparam logic CEIL_EN = 1'b0;
`endif

    logic [1:0]          state_q, state_d;
    logic [DIM_BITS-1:0] col_q, col_d;
    logic [DIM_BITS-1:0] row_q, row_d;
    logic [DIM_BITS-1:0] w_q, w_d;
    logic [DIM_BITS-1:0] h_q, h_d;
    logic [CH-1:0]       hold_q, hold_d;
    logic                out_valid_q, out_valid_d;
    logic [CH-1:0]       out_data_q, out_data_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                done_pend_q, done_pend_d;
    logic                err_q, err_d;

    logic [CH-1:0]       lb_q [LB_N];
    logic                lb_we;
    logic [LB_AW-1:0]    lb_widx;
    logic [CH-1:0]       lb_wdata;
    logic [LB_AW-1:0]    lb_ridx;
    logic [CH-1:0]       lb_rdata;

    logic                last_col;
    logic                last_row;
    logic                pair_ok;
    logic [CH-1:0]       pair;
    logic                cfg_ok;

    // Window bookkeeping: in ceil mode a trailing even column pairs with an implicit zero.
    always_comb begin
        last_col = (col_q == (w_q - ONE));
        last_row = (row_q == (h_q - ONE));
        pair_ok  = col_q[0] | (CEIL_EN & last_col);
        if (col_q[0]) begin
            pair = hold_q | in_data;
        end else begin
            pair = in_data;
        end
        cfg_ok = (cfg_width != '0) && (cfg_width <= MAXWD) && (cfg_height != '0);
        // DRAIN walks the buffer linearly; RUN reads the slot of the current column pair.
        if (state_q == S_DRAIN) begin
            lb_ridx = col_q[LB_AW-1:0];
        end else begin
            lb_ridx = col_q[LB_AW:1];
        end
        lb_rdata = lb_q[lb_ridx];
    end

    // Next-state, counter and output computation.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        w_d          = w_q;
        h_d          = h_q;
        hold_d       = hold_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        frame_done_d = done_pend_q;
        done_pend_d  = 1'b0;
        err_d        = err_q;
        lb_we        = 1'b0;
        lb_widx      = col_q[LB_AW:1];
        lb_wdata     = pair;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        state_d = S_RUN;
                        col_d   = '0;
                        row_d   = '0;
                        w_d     = cfg_width;
                        h_d     = cfg_height;
                        err_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
                if (in_valid) begin
                    err_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end

            S_RUN: begin
                if (in_valid) begin
                    if (!col_q[0]) begin
                        hold_d = in_data;
                    end else begin
                        hold_d = hold_q;
                    end
                    if (pair_ok && row_q[0]) begin
                        out_valid_d = 1'b1;
                        out_data_d  = lb_rdata | pair;
                    end else if (pair_ok && (CEIL_EN || !last_row)) begin
                        lb_we = 1'b1;
                    end else begin
                        lb_we = 1'b0;
                    end
                    if (!last_col) begin
                        col_d = col_q + ONE;
                    end else if (!last_row) begin
                        col_d = '0;
                        row_d = row_q + ONE;
                    end else begin
                        col_d = '0;
                        row_d = '0;
                        // A ceil-mode frame ending on an even row still owes the buffered row.
                        if (CEIL_EN && !row_q[0]) begin
                            state_d = S_DRAIN;
                        end else if (pair_ok && row_q[0]) begin
                            state_d     = S_IDLE;
                            done_pend_d = 1'b1;
                        end else begin
                            state_d      = S_IDLE;
                            frame_done_d = 1'b1;
                        end
                    end
                end else begin
                    state_d = S_RUN;
                end
            end

`ifdef BINPOOL_CEIL_EN
            S_DRAIN: begin
                out_valid_d = 1'b1;
                out_data_d  = lb_rdata;
                if (col_q == (((w_q + ONE) >> 1) - ONE)) begin
                    state_d     = S_IDLE;
                    col_d       = '0;
                    done_pend_d = 1'b1;
                end else begin
                    col_d = col_q + ONE;
                end
                if (in_valid) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            w_q          <= '0;
            h_q          <= '0;
            hold_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            done_pend_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            w_q          <= w_d;
            h_q          <= h_d;
            hold_q       <= hold_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            done_pend_q  <= done_pend_d;
            err_q        <= err_d;
        end
    end

    // Line buffer of even-row column pairs; contents need no reset.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb_q[lb_widx] <= lb_wdata;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_bin_maxpool_2x2.sv
// Directed self-checking bench for bin_maxpool_2x2; follows BINPOOL_CEIL_EN when it is defined.
module tb_bin_maxpool_2x2;

`ifdef BINPOOL_CEIL_EN
    localparam bit CEIL = 1'b1;
`else
    localparam bit CEIL = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [6:0]  cfg_width;
    logic [6:0]  cfg_height;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_valid;
    logic [63:0] out_data;
    logic        busy;
    logic        frame_done;
    logic        err;

    int          n_checks;
    int          n_fail;
    int          cyc;
    int          fd_cnt;
    logic        fd_after_last;
    logic [63:0] got_q[$];
    int          out_cyc[$];
    logic [63:0] exp_q[$];
    logic [63:0] pix [0:4095];

    bin_maxpool_2x2 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (out_valid) begin
            got_q.push_back(out_data);
            out_cyc.push_back(cyc);
        end
        if (frame_done) fd_cnt <= fd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        out_cyc.delete();
        fd_cnt = 0;
    endtask

    task automatic do_start(input int w, input int h);
        start      = 1'b1;
        cfg_width  = 7'(w);
        cfg_height = 7'(h);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [63:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Reference: OR of each 2x2 window clipped to the frame, in raster order.
    task automatic build_exp(input int w, input int h);
        int ow, oh;
        logic [63:0] v;
        exp_q.delete();
        ow = CEIL ? (w + 1) / 2 : w / 2;
        oh = CEIL ? (h + 1) / 2 : h / 2;
        for (int i = 0; i < oh; i++) begin
            for (int j = 0; j < ow; j++) begin
                v = '0;
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if ((2*i + dr) < h && (2*j + dc) < w) v |= pix[(2*i + dr)*w + 2*j + dc];
                exp_q.push_back(v);
            end
        end
    endtask

    task automatic run_frame(input string name, input int w, input int h, input bit gaps);
        int n;
        clear_mon();
        build_exp(w, h);
        do_start(w, h);
        chk({name, "_err_clr"}, 64'(err), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd1);
        for (int k = 0; k < w*h; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send(pix[k]);
        end
        fd_after_last = frame_done;
        for (int t = 0; t < 200 && fd_cnt == 0; t++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_fd_cnt"}, 64'(fd_cnt), 64'd1);
        chk({name, "_n_out"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_out%0d", name, i), got_q[i], exp_q[i]);
        chk({name, "_err"}, 64'(err), 64'd0);
        chk({name, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0; fd_cnt = 0;
        rst = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_fd", 64'(frame_done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // W=4,H=2 directed timing: outputs after row1 beats 1 and 3.
        clear_mon();
        do_start(4, 2);
        for (int i = 0; i < 8; i++) begin
            logic [63:0] d;
            d = 64'd1 << i;
            send(d);
            if (i == 5) begin
                chk("t1_ov5", 64'(out_valid), 64'd1);
                chk("t1_od5", out_data, 64'h33);
            end else if (i == 7) begin
                chk("t1_ov7", 64'(out_valid), 64'd1);
                chk("t1_od7", out_data, 64'hCC);
                chk("t1_fd_early", 64'(frame_done), 64'd0);
            end else begin
                chk($sformatf("t1_ov%0d", i), 64'(out_valid), 64'd0);
            end
        end
        @(posedge clk); #1;
        chk("t1_fd", 64'(frame_done), 64'd1);
        chk("t1_ov_after", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk("t1_fd_pulse", 64'(frame_done), 64'd0);
        chk("t1_n_out", 64'(got_q.size()), 64'd2);

        // Full-size random frame with idle gaps.
        for (int k = 0; k < 4096; k++) pix[k] = {$urandom, $urandom};
        pix[0][63] = 1'b1;
        run_frame("t2", 64, 64, 1'b1);

        // W=3,H=3 all ones.
        for (int k = 0; k < 9; k++) pix[k] = 64'hFFFF_FFFF_FFFF_FFFF;
        run_frame("t3", 3, 3, 1'b0);
        chk("t3_count", 64'(got_q.size()), CEIL ? 64'd4 : 64'd1);
`ifdef BINPOOL_CEIL_EN
        if (out_cyc.size() == 4) chk("t3_drain_b2b", 64'(out_cyc[3] - out_cyc[2]), 64'd1);
        else chk("t3_drain_n", 64'(out_cyc.size()), 64'd4);
`endif

        // Illegal configurations, then a legal frame clears err.
        do_start(0, 2);
        chk("t4_w0_err", 64'(err), 64'd1);
        chk("t4_w0_busy", 64'(busy), 64'd0);
        do_start(65, 2);
        chk("t4_w65_err", 64'(err), 64'd1);
        chk("t4_w65_busy", 64'(busy), 64'd0);
        pix[0] = 64'h1; pix[1] = 64'h2; pix[2] = 64'h4; pix[3] = 64'h8;
        run_frame("t4", 2, 2, 1'b0);
        chk("t4_val", (got_q.size() > 0) ? got_q[0] : 64'hDEAD, 64'hF);

        // Stray beat in IDLE, then reset mid-frame with an output in flight.
        clear_mon();
        send(64'h5A);
        chk("t5_idle_err", 64'(err), 64'd1);
        chk("t5_idle_ov", 64'(out_valid), 64'd0);
        for (int k = 0; k < 12; k++) pix[k] = {$urandom, $urandom};
        do_start(3, 4);
        chk("t5_err_clr", 64'(err), 64'd0);
        for (int k = 0; k < 5; k++) send(pix[k]);
        chk("t5_ov_pre", 64'(out_valid), 64'd1);
        chk("t5_od_pre", out_data, pix[0] | pix[1] | pix[3] | pix[4]);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_ov", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) pix[k] = {$urandom, $urandom};
        run_frame("t5", 4, 2, 1'b0);

        // W=1,H=5.
        for (int k = 0; k < 5; k++) pix[k] = 64'h1 << (k * 8);
        run_frame("t6", 1, 5, 1'b0);
        chk("t6_n", 64'(got_q.size()), CEIL ? 64'd3 : 64'd0);
        if (!CEIL) chk("t6_fd_timing", 64'(fd_after_last), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
